// File: rtl/riscv_instr_fetch_ctrl.sv
// riscv_instr_fetch_ctrl: instruction fetch controller, one outstanding memory transaction, pushes returned words into the fetch FIFO.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_i                        core enables fetching
//   branch_i, branch_addr_i      redirect pulse and byte target (clears the FIFO)
//   hwlp_i, hwlp_addr_i          hardware-loop jump pulse and target (no clear)
//   instr_req_o/addr_o/gnt_i     memory request channel
//   instr_rvalid_i/rdata_i       memory response channel
//   fifo_valid_o/addr_o/rdata_o  FIFO push port, fifo_ready_i gates new requests
//   fifo_clear_o                 FIFO flush on branch
//   fifo_replace2_o, fifo_is_hwlp_o  mark the first push after a hardware-loop jump
//   busy_o                       a memory transaction is outstanding
module riscv_instr_fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        hwlp_i,
    input  logic [31:0] hwlp_addr_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        fifo_valid_o,
    output logic [31:0] fifo_addr_o,
    output logic [31:0] fifo_rdata_o,
    input  logic        fifo_ready_i,
    output logic        fifo_clear_o,
    output logic        fifo_replace2_o,
    output logic        fifo_is_hwlp_o,
    output logic        busy_o
);
    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID, WAIT_ABORTED} state_t;
    state_t      r_state, w_next;
    logic [31:0] r_fetch_addr;
    logic [31:0] r_resp_addr;
    logic        r_hwlp_pend;
    logic        w_redirect, w_can_req, w_grant;

    assign w_redirect      = branch_i | hwlp_i;
    assign w_can_req       = req_i & fifo_ready_i & ~w_redirect;
    assign w_grant         = instr_req_o & instr_gnt_i;
    assign instr_addr_o    = {r_fetch_addr[31:2], 2'b00};
    assign fifo_addr_o     = r_resp_addr;
    assign fifo_rdata_o    = instr_rdata_i;
    assign fifo_clear_o    = branch_i;
    assign fifo_replace2_o = fifo_valid_o & r_hwlp_pend;
    assign fifo_is_hwlp_o  = fifo_valid_o & r_hwlp_pend;
    assign busy_o          = (r_state == WAIT_RVALID) || (r_state == WAIT_ABORTED);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        instr_req_o  = 1'b0;
        fifo_valid_o = 1'b0;
        case (r_state)
            IDLE: begin
                instr_req_o = w_can_req;
                if (w_can_req) w_next = instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
            end
            WAIT_GNT: begin
                // the request is held until granted; a granted word hit by a redirect must still be drained
                instr_req_o = 1'b1;
                if (w_redirect)       w_next = instr_gnt_i ? WAIT_ABORTED : IDLE;
                else if (instr_gnt_i) w_next = WAIT_RVALID;
            end
            WAIT_RVALID: begin
                if (w_redirect) w_next = instr_rvalid_i ? IDLE : WAIT_ABORTED;
                else if (instr_rvalid_i) begin
                    fifo_valid_o = 1'b1;
                    instr_req_o  = w_can_req;
                    w_next       = !w_can_req ? IDLE : instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
                end
            end
            WAIT_ABORTED: if (instr_rvalid_i) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_addr <= 32'h0;
            r_resp_addr  <= 32'h0;
            r_hwlp_pend  <= 1'b0;
        end else begin
            if (branch_i)     r_fetch_addr <= branch_addr_i;
            else if (hwlp_i)  r_fetch_addr <= hwlp_addr_i;
            else if (w_grant) r_fetch_addr <= {r_fetch_addr[31:2], 2'b00} + 32'd4;
            // bit 1 survives only for a halfword redirect target; sequential addresses are word aligned
            if (w_grant) r_resp_addr <= r_fetch_addr & 32'hFFFF_FFFE;
            if (branch_i)          r_hwlp_pend <= 1'b0;
            else if (hwlp_i)       r_hwlp_pend <= 1'b1;
            else if (fifo_valid_o) r_hwlp_pend <= 1'b0;
        end
    end
endmodule

// File: tb/tb_riscv_instr_fetch_ctrl.sv
// tb_riscv_instr_fetch_ctrl: directed self-checking bench for riscv_instr_fetch_ctrl.
module tb_riscv_instr_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst, req_i, branch_i, hwlp_i, instr_gnt_i, instr_rvalid_i, fifo_ready_i;
    logic [31:0] branch_addr_i, hwlp_addr_i, instr_rdata_i;
    logic        instr_req_o, fifo_valid_o, fifo_clear_o, fifo_replace2_o, fifo_is_hwlp_o, busy_o;
    logic [31:0] instr_addr_o, fifo_addr_o, fifo_rdata_o;
    int          n_chk = 0;
    int          n_fail = 0;

    riscv_instr_fetch_ctrl dut (
        .clk(clk), .rst(rst), .req_i(req_i),
        .branch_i(branch_i), .branch_addr_i(branch_addr_i),
        .hwlp_i(hwlp_i), .hwlp_addr_i(hwlp_addr_i),
        .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
        .fifo_valid_o(fifo_valid_o), .fifo_addr_o(fifo_addr_o), .fifo_rdata_o(fifo_rdata_o),
        .fifo_ready_i(fifo_ready_i), .fifo_clear_o(fifo_clear_o),
        .fifo_replace2_o(fifo_replace2_o), .fifo_is_hwlp_o(fifo_is_hwlp_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; req_i = 0; branch_i = 0; hwlp_i = 0; instr_gnt_i = 0; instr_rvalid_i = 0;
        fifo_ready_i = 1; branch_addr_i = 0; hwlp_addr_i = 0; instr_rdata_i = 0;
        tick(); tick();
        rst = 0; #1;
        chk("rst_req", instr_req_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", fifo_valid_o, 0);
        chk("rst_addr", instr_addr_o, 0);

        // sequential fetch after a branch to 0x100
        tick();
        req_i = 1; branch_i = 1; branch_addr_i = 32'h100; #1;
        chk("br_clear", fifo_clear_o, 1);
        chk("br_noreq", instr_req_o, 0);
        tick();
        branch_i = 0; instr_gnt_i = 1; #1;
        chk("seq_req", instr_req_o, 1);
        chk("seq_addr0", instr_addr_o, 32'h100);
        tick();
        instr_gnt_i = 0; instr_rvalid_i = 1; instr_rdata_i = 32'hAABBCCDD; #1;
        chk("seq_busy", busy_o, 1);
        chk("seq_valid", fifo_valid_o, 1);
        chk("seq_faddr", fifo_addr_o, 32'h100);
        chk("seq_rdata", fifo_rdata_o, 32'hAABBCCDD);
        chk("seq_rep2", fifo_replace2_o, 0);
        chk("seq_addr1", instr_addr_o, 32'h104);
        chk("seq_req1", instr_req_o, 1);
        tick();
        instr_rvalid_i = 0; #1;
        chk("gnt_hold_req", instr_req_o, 1);
        chk("gnt_hold_addr", instr_addr_o, 32'h104);
        chk("gnt_novalid", fifo_valid_o, 0);
        chk("gnt_nobusy", busy_o, 0);
        instr_gnt_i = 1;
        tick();
        instr_rvalid_i = 1; instr_rdata_i = 32'h11111111; #1;
        chk("b2b_faddr", fifo_addr_o, 32'h104);
        chk("b2b_addr", instr_addr_o, 32'h108);
        tick();

        // branch to 0x400 while 0x108 is outstanding
        instr_gnt_i = 0; instr_rvalid_i = 0; branch_i = 1; branch_addr_i = 32'h400; #1;
        chk("ab_clear", fifo_clear_o, 1);
        chk("ab_noreq", instr_req_o, 0);
        tick();
        branch_i = 0; instr_rvalid_i = 1; instr_rdata_i = 32'hDEADBEEF; #1;
        chk("ab_discard", fifo_valid_o, 0);
        chk("ab_busy", busy_o, 1);
        chk("ab_noreq2", instr_req_o, 0);
        tick();
        instr_rvalid_i = 0; #1;
        chk("ab_req", instr_req_o, 1);
        chk("ab_addr", instr_addr_o, 32'h400);
        instr_gnt_i = 1;
        tick();
        instr_gnt_i = 0; instr_rvalid_i = 1; instr_rdata_i = 32'h40404040; req_i = 0; #1;
        chk("noreq_push", fifo_valid_o, 1);
        chk("noreq_faddr", fifo_addr_o, 32'h400);
        chk("noreq_req", instr_req_o, 0);
        tick();

        // halfword branch target 0x202
        instr_rvalid_i = 0; req_i = 1; branch_i = 1; branch_addr_i = 32'h202;
        tick();
        branch_i = 0; instr_gnt_i = 1; #1;
        chk("hw_addr0", instr_addr_o, 32'h200);
        tick();
        instr_rvalid_i = 1; #1;
        chk("hw_faddr0", fifo_addr_o, 32'h202);
        chk("hw_addr1", instr_addr_o, 32'h204);
        tick();
        instr_gnt_i = 0; req_i = 0; #1;
        chk("hw_faddr1", fifo_addr_o, 32'h204);
        tick();

        // hardware-loop jump to 0x80 from idle
        instr_rvalid_i = 0; req_i = 1; hwlp_i = 1; hwlp_addr_i = 32'h80; #1;
        chk("hl_noclear", fifo_clear_o, 0);
        chk("hl_noreq", instr_req_o, 0);
        tick();
        hwlp_i = 0; instr_gnt_i = 1; #1;
        chk("hl_addr", instr_addr_o, 32'h80);
        tick();
        instr_rvalid_i = 1; #1;
        chk("hl_valid", fifo_valid_o, 1);
        chk("hl_faddr", fifo_addr_o, 32'h80);
        chk("hl_rep2", fifo_replace2_o, 1);
        chk("hl_ishwlp", fifo_is_hwlp_o, 1);
        chk("hl_clear", fifo_clear_o, 0);
        tick();
        instr_gnt_i = 0; req_i = 0; #1;
        chk("hl2_valid", fifo_valid_o, 1);
        chk("hl2_rep2", fifo_replace2_o, 0);
        chk("hl2_ishwlp", fifo_is_hwlp_o, 0);
        tick();

        // backpressure and address wrap
        instr_rvalid_i = 0; req_i = 1; fifo_ready_i = 0; branch_i = 1; branch_addr_i = 32'hFFFFFFFC;
        tick();
        branch_i = 0; #1;
        chk("bp_noreq", instr_req_o, 0);
        fifo_ready_i = 1; #1;
        chk("wrap_req", instr_req_o, 1);
        chk("wrap_addr0", instr_addr_o, 32'hFFFFFFFC);
        instr_gnt_i = 1;
        tick();
        instr_gnt_i = 1; instr_rvalid_i = 1; #1;
        chk("wrap_faddr", fifo_addr_o, 32'hFFFFFFFC);
        chk("wrap_addr1", instr_addr_o, 32'h0);
        tick();

        // reset while a transaction is outstanding
        rst = 1; req_i = 0; instr_gnt_i = 0; instr_rvalid_i = 0;
        tick();
        rst = 0; instr_rvalid_i = 1; #1;
        chk("rm_novalid", fifo_valid_o, 0);
        chk("rm_busy", busy_o, 0);
        chk("rm_addr", instr_addr_o, 32'h0);
        tick();

        // branch wins over a simultaneous hardware-loop jump
        instr_rvalid_i = 0; branch_i = 1; branch_addr_i = 32'h300; hwlp_i = 1; hwlp_addr_i = 32'h500;
        tick();
        branch_i = 0; hwlp_i = 0; req_i = 1; instr_gnt_i = 1; #1;
        chk("pri_addr", instr_addr_o, 32'h300);
        tick();
        instr_gnt_i = 0; req_i = 0; instr_rvalid_i = 1; #1;
        chk("pri_valid", fifo_valid_o, 1);
        chk("pri_rep2", fifo_replace2_o, 0);
        tick();
        instr_rvalid_i = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
